// File: rtl/par_arbiter_m2s_by_id.sv
// Master-to-slave arbiter for one AXI address channel: grants one master, holds it until the handshake.
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module par_arbiter_m2s_by_id #(
    parameter int unsigned MasterCount  = 2,
    parameter int unsigned PayloadWidth = 32
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic [MasterCount-1:0]              VALID_M,
    input  logic [MasterCount*PayloadWidth-1:0] PAYLOAD_M,
    output logic [MasterCount-1:0]              READY_M,
    output logic                                VALID_S,
    output logic [PayloadWidth-1:0]             PAYLOAD_S,
    output logic [3:0]                          ID_S,
    input  logic                                READY_S,
    output logic                                BUSY
);

    localparam int unsigned IdW = 4;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [IdW-1:0] grant_q, grant_d;
    logic [IdW-1:0] rr_ptr;
    logic           any_req;
    logic           hi_found;
    logic [IdW-1:0] low_all;
    logic [IdW-1:0] low_hi;
    logic [IdW-1:0] winner;

`ifdef ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IdW-1:0] ptr_q, ptr_d;
    logic           handshake;

    assign handshake = (state_q == StGrant) && READY_S;

    // Pointer moves just past the master that completed its handshake.
    always_comb begin
        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (grant_q == IdW'(MasterCount - 1)) ? '0 : grant_q + IdW'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign rr_ptr = ptr_q;
`endif

    // Lowest requester at/above the pointer wins, else the lowest requester overall (wrap).
    always_comb begin
        any_req  = 1'b0;
        hi_found = 1'b0;
        low_all  = '0;
        low_hi   = '0;
        for (int i = int'(MasterCount) - 1; i >= 0; i--) begin
            if (VALID_M[i]) begin
                any_req = 1'b1;
                low_all = IdW'(i);
                if (IdW'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    low_hi   = IdW'(i);
                end
            end
        end
        winner = hi_found ? low_hi : low_all;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StGrant;
                    grant_d = winner;
                end
            end
            StGrant: begin
                if (READY_S) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    assign BUSY    = (state_q == StGrant);
    assign VALID_S = BUSY;
    assign ID_S    = BUSY ? grant_q : '0;

    // Payload and READY route through from the held winner only while granted.
    always_comb begin
        PAYLOAD_S = '0;
        READY_M   = '0;
        for (int i = 0; i < int'(MasterCount); i++) begin
            if (BUSY && (grant_q == IdW'(i))) begin
                PAYLOAD_S  = PAYLOAD_M[i*PayloadWidth +: PayloadWidth];
                READY_M[i] = READY_S;
            end
        end
    end

endmodule

// File: tb/tb_par_arbiter_m2s_by_id.sv
// Self-checking bench for par_arbiter_m2s_by_id: directed tables, corner sequences, random vs. model.
module tb_par_arbiter_m2s_by_id;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   v2;
    logic [63:0]  p2;
    logic         rs2;
    logic [1:0]   rm2;
    logic         vs2;
    logic [31:0]  ps2;
    logic [3:0]   id2;
    logic         busy2;

    logic [3:0]   v4;
    logic [127:0] p4;
    logic         rs4;
    logic [3:0]   rm4;
    logic         vs4;
    logic [31:0]  ps4;
    logic [3:0]   id4;
    logic         busy4;

    par_arbiter_m2s_by_id #(.MasterCount(2), .PayloadWidth(32)) dut2 (
        .ACLK(clk), .ARESETn(rst_n), .VALID_M(v2), .PAYLOAD_M(p2), .READY_M(rm2),
        .VALID_S(vs2), .PAYLOAD_S(ps2), .ID_S(id2), .READY_S(rs2), .BUSY(busy2)
    );

    par_arbiter_m2s_by_id #(.MasterCount(4), .PayloadWidth(32)) dut4 (
        .ACLK(clk), .ARESETn(rst_n), .VALID_M(v4), .PAYLOAD_M(p4), .READY_M(rm4),
        .VALID_S(vs4), .PAYLOAD_S(ps4), .ID_S(id4), .READY_S(rs4), .BUSY(busy4)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first valid index scanning from ptr, modulo mc; -1 if none.
    function automatic int pick(input int mc, input logic [3:0] v, input int ptr);
        for (int k = 0; k < mc; k++) begin
            if (v[(ptr + k) % mc]) return (ptr + k) % mc;
        end
        return -1;
    endfunction

    typedef struct {
        logic [1:0]  v;
        logic        rs;
        logic        vs;
        logic [3:0]  id;
        logic [1:0]  rm;
        logic [31:0] pay;
    } vec_t;

    vec_t tbl [7];

    localparam logic [31:0] Pay0 = 32'hA0A0_0000;
    localparam logic [31:0] Pay1 = 32'h0000_1000;

    int          m_busy [2];
    int          m_win  [2];
    int          m_ptr  [2];
    int          mcs    [2];
    logic [3:0]  vv     [2];
    logic [31:0] pay    [2][4];
    logic        rsr    [2];

    initial begin
        // Both masters held valid, READY_S high: handshake, idle gap, next grant.
        tbl[0] = '{v: 2'b11, rs: 1'b1, vs: 1'b1, id: 4'd0, rm: 2'b01, pay: Pay0};
        tbl[1] = '{v: 2'b11, rs: 1'b1, vs: 1'b0, id: 4'd0, rm: 2'b00, pay: 32'h0};
`ifdef ARB_FIXED_PRIO_EN
        tbl[2] = '{v: 2'b11, rs: 1'b1, vs: 1'b1, id: 4'd0, rm: 2'b01, pay: Pay0};
`else
        tbl[2] = '{v: 2'b11, rs: 1'b1, vs: 1'b1, id: 4'd1, rm: 2'b10, pay: Pay1};
`endif
        tbl[3] = '{v: 2'b11, rs: 1'b1, vs: 1'b0, id: 4'd0, rm: 2'b00, pay: 32'h0};
        tbl[4] = '{v: 2'b11, rs: 1'b1, vs: 1'b1, id: 4'd0, rm: 2'b01, pay: Pay0};
        tbl[5] = '{v: 2'b11, rs: 1'b1, vs: 1'b0, id: 4'd0, rm: 2'b00, pay: 32'h0};
`ifdef ARB_FIXED_PRIO_EN
        tbl[6] = '{v: 2'b11, rs: 1'b1, vs: 1'b1, id: 4'd0, rm: 2'b01, pay: Pay0};
`else
        tbl[6] = '{v: 2'b11, rs: 1'b1, vs: 1'b1, id: 4'd1, rm: 2'b10, pay: Pay1};
`endif

        v2 = 2'b11; p2 = {Pay1, Pay0}; rs2 = 1'b0;
        v4 = 4'b0;  p4 = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000}; rs4 = 1'b0;

        // Reset with requests pending: everything quiet.
        step();
        step();
        #1;
        chk("rst_valid_s", 64'(vs2), 64'd0);
        chk("rst_ready_m", 64'(rm2), 64'd0);
        chk("rst_payload", 64'(ps2), 64'd0);
        chk("rst_id", 64'(id2), 64'd0);
        chk("rst_busy", 64'(busy2), 64'd0);
        rst_n = 1'b1;
        step();
        #1;
        chk("first_valid_s", 64'(vs2), 64'd1);
        chk("first_id", 64'(id2), 64'd0);
        chk("first_payload", 64'(ps2), 64'(Pay0));
        chk("first_busy", 64'(busy2), 64'd1);

        for (int i = 0; i < 7; i++) begin
            step();
            v2 = tbl[i].v;
            rs2 = tbl[i].rs;
            #1;
            chk($sformatf("tbl%0d_valid_s", i), 64'(vs2), 64'(tbl[i].vs));
            chk($sformatf("tbl%0d_id", i), 64'(id2), 64'(tbl[i].id));
            chk($sformatf("tbl%0d_ready_m", i), 64'(rm2), 64'(tbl[i].rm));
            chk($sformatf("tbl%0d_payload", i), 64'(ps2), 64'(tbl[i].pay));
        end

        // Master 1 alone, slave stalls 5 cycles then accepts.
        step();
        v2 = 2'b10; rs2 = 1'b0;
        #1;
        chk("stall_idle_valid_s", 64'(vs2), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            rs2 = (i == 5);
            #1;
            chk($sformatf("stall%0d_valid_s", i), 64'(vs2), 64'd1);
            chk($sformatf("stall%0d_id", i), 64'(id2), 64'd1);
            chk($sformatf("stall%0d_payload", i), 64'(ps2), 64'(Pay1));
            chk($sformatf("stall%0d_ready_m", i), 64'(rm2), (i == 5) ? 64'd2 : 64'd0);
        end
        step();
        v2 = 2'b00; rs2 = 1'b0;
        #1;
        chk("stall_done_valid_s", 64'(vs2), 64'd0);
        chk("stall_done_busy", 64'(busy2), 64'd0);

        // Reset in the middle of a grant, then arbitration restarts from master 0.
        step();
        v2 = 2'b01; rs2 = 1'b1;
        #1;
        chk("mrst_idle_valid_s", 64'(vs2), 64'd0);
        step();
        v2 = 2'b11;
        #1;
        chk("mrst_g0_id", 64'(id2), 64'd0);
        chk("mrst_g0_ready_m", 64'(rm2), 64'd1);
        step();
        v2 = 2'b10; rs2 = 1'b0;
        #1;
        chk("mrst_gap_valid_s", 64'(vs2), 64'd0);
        step();
        rs2 = 1'b1;
        #1;
        chk("mrst_g1_ready_m", 64'(rm2), 64'd2);
        chk("mrst_g1_id", 64'(id2), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid_s", 64'(vs2), 64'd0);
        chk("mrst_ready_m", 64'(rm2), 64'd0);
        chk("mrst_busy", 64'(busy2), 64'd0);
        chk("mrst_id", 64'(id2), 64'd0);
        v2 = 2'b11; rs2 = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        #1;
        chk("mrst_restart_valid_s", 64'(vs2), 64'd1);
        chk("mrst_restart_id", 64'(id2), 64'd0);
        v2 = 2'b00;

        // Four masters: pointer at 2 with requests 1010 picks 3, then wraps to 1.
        v4 = 4'b0010; rs4 = 1'b1;
        step();
        #1;
        chk("m4_g1_id", 64'(id4), 64'd1);
        chk("m4_g1_ready_m", 64'(rm4), 64'h2);
        v4 = 4'b1010;
        step();
        #1;
        chk("m4_gap1_valid_s", 64'(vs4), 64'd0);
        step();
        #1;
`ifdef ARB_FIXED_PRIO_EN
        chk("m4_g2_id", 64'(id4), 64'd1);
        chk("m4_g2_ready_m", 64'(rm4), 64'h2);
`else
        chk("m4_g2_id", 64'(id4), 64'd3);
        chk("m4_g2_ready_m", 64'(rm4), 64'h8);
        chk("m4_g2_payload", 64'(ps4), 64'h4444_0003);
`endif
        step();
        #1;
        chk("m4_gap2_valid_s", 64'(vs4), 64'd0);
        step();
        #1;
        chk("m4_g3_id", 64'(id4), 64'd1);
        v4 = 4'b0000;

        // Randomized traffic on both instances against the reference model.
        step();
        rst_n = 1'b0; v2 = '0; v4 = '0; rs2 = 1'b0; rs4 = 1'b0;
        #1;
        rst_n = 1'b1;
        mcs[0] = 2; mcs[1] = 4;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_win[d] = 0; m_ptr[d] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                vv[d] = '0;
                for (int m = 0; m < mcs[d]; m++) begin
                    if (m_busy[d] != 0 && m_win[d] == m) vv[d][m] = 1'b1;
                    else vv[d][m] = ($urandom_range(0, 2) != 0);
                end
                for (int m = 0; m < 4; m++) pay[d][m] = $urandom;
                rsr[d] = 1'($urandom_range(0, 1));
            end
            v2 = vv[0][1:0]; rs2 = rsr[0]; p2 = {pay[0][1], pay[0][0]};
            v4 = vv[1];      rs4 = rsr[1]; p4 = {pay[1][3], pay[1][2], pay[1][1], pay[1][0]};
            #1;
            for (int d = 0; d < 2; d++) begin
                logic [63:0] e_vs, e_id, e_pay, e_rm;
                e_vs  = 64'(m_busy[d] != 0);
                e_id  = (m_busy[d] != 0) ? 64'(m_win[d]) : 64'd0;
                e_pay = (m_busy[d] != 0) ? 64'(pay[d][m_win[d]]) : 64'd0;
                e_rm  = (m_busy[d] != 0 && rsr[d]) ? (64'd1 << m_win[d]) : 64'd0;
                chk($sformatf("rnd%0d_d%0d_valid_s", cyc, d), d == 0 ? 64'(vs2) : 64'(vs4), e_vs);
                chk($sformatf("rnd%0d_d%0d_busy", cyc, d), d == 0 ? 64'(busy2) : 64'(busy4), e_vs);
                chk($sformatf("rnd%0d_d%0d_id", cyc, d), d == 0 ? 64'(id2) : 64'(id4), e_id);
                chk($sformatf("rnd%0d_d%0d_payload", cyc, d), d == 0 ? 64'(ps2) : 64'(ps4), e_pay);
                chk($sformatf("rnd%0d_d%0d_ready_m", cyc, d), d == 0 ? 64'(rm2) : 64'(rm4), e_rm);
                if (m_busy[d] != 0) begin
                    if (rsr[d]) begin
                        m_busy[d] = 0;
`ifdef ARB_FIXED_PRIO_EN
                        m_ptr[d] = 0;
`else
                        m_ptr[d] = (m_win[d] + 1) % mcs[d];
`endif
                    end
                end else begin
                    int w;
                    w = pick(mcs[d], vv[d], m_ptr[d]);
                    if (w >= 0) begin
                        m_busy[d] = 1;
                        m_win[d] = w;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
